// File: rtl/pb_gesture_decoder.sv
// Push-button gesture classifier: turns debounced press/release pulses into
// registered single/double click, long press and auto-repeat events.
module pb_gesture_decoder #(
  parameter int unsigned LONG_CYCLES       = 50_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 25_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic PB_pressed_pulse,
  input  logic PB_released_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held,
  output logic busy
);

  localparam int unsigned MAX_LG     = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES
                                                                         : DOUBLE_GAP_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             press_c;
  logic             release_c;
  logic             single_c;
  logic             double_c;
  logic             long_c;
  logic             repeat_c;

  // Coincident press and release pulses cancel each other out.
  assign press_c   = PB_pressed_pulse & ~PB_released_pulse;
  assign release_c = PB_released_pulse & ~PB_pressed_pulse;

  // Next-state, counter and event decision.
  always_comb begin
    state_nxt_c = state;
    cnt_nxt_c   = cnt + CNT_W'(1);
    single_c    = 1'b0;
    double_c    = 1'b0;
    long_c      = 1'b0;
    repeat_c    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt_c = '0;
        if (press_c) state_nxt_c = PRESS1;
      end
      PRESS1: begin
        if (release_c) begin
          state_nxt_c = WAIT2;
        end else if (cnt == LONG_LAST) begin
          state_nxt_c = LONG;
          long_c      = 1'b1;
        end
      end
      LONG: begin
        if (release_c) begin
          state_nxt_c = IDLE;
        end else if (cnt == REPEAT_LAST) begin
          repeat_c  = 1'b1;
          cnt_nxt_c = '0;
        end
      end
      WAIT2: begin
        if (press_c) begin
          state_nxt_c = PRESS2;
        end else if (cnt == GAP_LAST) begin
          state_nxt_c = IDLE;
          single_c    = 1'b1;
        end
      end
      PRESS2: begin
        if (release_c) begin
          state_nxt_c = IDLE;
          double_c    = 1'b1;
        end
      end
      default: begin
        state_nxt_c = IDLE;
        cnt_nxt_c   = '0;
      end
    endcase
    if (state_nxt_c != state) cnt_nxt_c = '0;
  end

  // State, counter and registered outputs; held/busy decode the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt_c;
      cnt          <= cnt_nxt_c;
      single_click <= single_c;
      double_click <= double_c;
      long_press   <= long_c;
      repeat_pulse <= repeat_c;
      held         <= (state_nxt_c == PRESS1) || (state_nxt_c == PRESS2) ||
                      (state_nxt_c == LONG);
      busy         <= (state_nxt_c != IDLE);
    end
  end

endmodule
